// File: rtl/ahb2apb_bridge_p.sv
// Parametrised AHB-Lite slave to APB4 master bridge: one APB transfer per accepted AHB beat.
// Optional feature: define AHB2APB_PSLVERR_EN to turn APB pslverr into an AHB ERROR response.
module ahb2apb_bridge_p #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int NUM_SLV = 3,
    parameter int SEL_LSB = 28
) (
    input  logic                hclk,
    input  logic                hresetn,
    input  logic [ADDR_W-1:0]   haddr,
    input  logic [1:0]          htrans,
    input  logic                hwrite,
    input  logic [2:0]          hsize,
    input  logic [2:0]          hburst,
    input  logic [DATA_W-1:0]   hwdata,
    input  logic                hreadyin,
    output logic [DATA_W-1:0]   hrdata,
    output logic                hreadyout,
    output logic [1:0]          hresp,
    output logic [NUM_SLV-1:0]  psel,
    output logic                penable,
    output logic [ADDR_W-1:0]   paddr,
    output logic                pwrite,
    output logic [DATA_W-1:0]   pwdata,
    output logic [DATA_W/8-1:0] pstrb,
    input  logic [DATA_W-1:0]   prdata,
    input  logic                pready,
    input  logic                pslverr
);

    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int IDX_W  = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_WDATA, S_SETUP, S_ACCESS, S_ERR1, S_ERR2
    } state_t;

    state_t state, next_state;

    logic [IDX_W-1:0]   idx_q, dec_idx, idx_nxt;
    logic [OFF_W-1:0]   size_mask;
    logic [STRB_W-1:0]  strb_mask;
    logic               accept, dec_err, load, slv_err;
    logic               unused_ok;

    logic               hreadyout_d, penable_d, pwrite_d;
    logic [1:0]         hresp_d;
    logic [NUM_SLV-1:0] psel_d;
    logic [ADDR_W-1:0]  paddr_d;
    logic [DATA_W-1:0]  pwdata_d, hrdata_d;
    logic [STRB_W-1:0]  pstrb_d;

`ifdef AHB2APB_PSLVERR_EN
    assign slv_err   = pslverr;
    assign unused_ok = ^{hburst, htrans[0]};
`else
    assign slv_err   = 1'b0;
    assign unused_ok = ^{hburst, htrans[0], pslverr};
`endif

    // Address-phase decode: slave index, size/alignment checks and byte lanes.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch can be inferred.
        dec_idx   = '0;
        if (NUM_SLV > 1) dec_idx = haddr[SEL_LSB +: IDX_W];
        size_mask = OFF_W'((32'd1 << hsize) - 32'd1);
        strb_mask = STRB_W'(((32'd1 << (32'd1 << hsize)) - 32'd1) << haddr[OFF_W-1:0]);
        dec_err   = (int'(dec_idx) >= NUM_SLV)
                 || ((32'd8 << hsize) > 32'(DATA_W))
                 || (|(haddr[OFF_W-1:0] & size_mask));
    end

    assign accept  = hreadyin && htrans[1] && hreadyout && (state == S_IDLE || state == S_ERR2);
    assign load    = accept && !dec_err;
    assign idx_nxt = load ? dec_idx : idx_q;

    // State and output registers.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state     <= S_IDLE;
            idx_q     <= '0;
            hreadyout <= 1'b1;
            hresp     <= 2'b00;
            hrdata    <= '0;
            psel      <= '0;
            penable   <= 1'b0;
            paddr     <= '0;
            pwrite    <= 1'b0;
            pwdata    <= '0;
            pstrb     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state     <= next_state;
            idx_q     <= idx_nxt;
            hreadyout <= hreadyout_d;
            hresp     <= hresp_d;
            hrdata    <= hrdata_d;
            psel      <= psel_d;
            penable   <= penable_d;
            paddr     <= paddr_d;
            pwrite    <= pwrite_d;
            pwdata    <= pwdata_d;
            pstrb     <= pstrb_d;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE, S_ERR2: begin
                next_state = S_IDLE;
                if (accept) begin
                    if (dec_err)     next_state = S_ERR1;
                    else if (hwrite) next_state = S_WDATA;
                    else             next_state = S_SETUP;
                end
            end
            S_WDATA:  next_state = S_SETUP;
            S_SETUP:  next_state = S_ACCESS;
            S_ACCESS: if (pready) next_state = slv_err ? S_ERR1 : S_IDLE;
            S_ERR1:   next_state = S_ERR2;
            default:  next_state = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they are registered yet on time.
    always_comb begin
        hreadyout_d = (next_state == S_IDLE) || (next_state == S_ERR2);
        hresp_d     = ((next_state == S_ERR1) || (next_state == S_ERR2)) ? 2'b01 : 2'b00;
        penable_d   = (next_state == S_ACCESS);
        psel_d      = '0;
        if (next_state == S_SETUP || next_state == S_ACCESS)
            psel_d = NUM_SLV'(1) << idx_nxt;
        paddr_d     = load ? haddr : paddr;
        pwrite_d    = load ? hwrite : pwrite;
        pstrb_d     = pstrb;
        if (load) pstrb_d = hwrite ? strb_mask : '0;
        pwdata_d    = (state == S_WDATA) ? hwdata : pwdata;
        hrdata_d    = hrdata;
        if (state == S_ACCESS && pready && !pwrite && !slv_err)
            hrdata_d = prdata;
    end

endmodule

// File: tb/tb_ahb2apb_bridge_p.sv
// Self-checking bench for ahb2apb_bridge_p: transaction-level timeline model plus literal checks.
module tb_ahb2apb_bridge_p;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 32;
    localparam int NUM_SLV = 3;
    localparam int SEL_LSB = 28;
`ifdef AHB2APB_PSLVERR_EN
    localparam bit SLVERR_EN = 1'b1;
`else
    localparam bit SLVERR_EN = 1'b0;
`endif

    logic        hclk = 1'b0;
    logic        hresetn = 1'b0;
    logic [31:0] haddr = '0;
    logic [1:0]  htrans = 2'b00;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = 3'd2;
    logic [2:0]  hburst = 3'd0;
    logic [31:0] hwdata = '0;
    logic        hreadyin = 1'b1;
    logic [31:0] hrdata;
    logic        hreadyout;
    logic [1:0]  hresp;
    logic [2:0]  psel;
    logic        penable;
    logic [31:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [31:0] prdata = '0;
    logic        pready = 1'b0;
    logic        pslverr = 1'b0;

    always #5 hclk = ~hclk;

    ahb2apb_bridge_p #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_SLV(NUM_SLV), .SEL_LSB(SEL_LSB)
    ) dut (
        .hclk(hclk), .hresetn(hresetn), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
        .hsize(hsize), .hburst(hburst), .hwdata(hwdata), .hreadyin(hreadyin),
        .hrdata(hrdata), .hreadyout(hreadyout), .hresp(hresp), .psel(psel),
        .penable(penable), .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata),
        .pstrb(pstrb), .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected bus state for the current cycle, maintained by the transaction tasks.
    logic        exp_valid = 1'b0;
    logic        exp_hreadyout = 1'b1;
    logic [1:0]  exp_hresp = 2'b00;
    logic [31:0] exp_hrdata = '0;
    logic [2:0]  exp_psel = '0;
    logic        exp_penable = 1'b0;
    logic [31:0] exp_paddr = '0;
    logic        exp_pwrite = 1'b0;
    logic [31:0] exp_pwdata = '0;
    logic [3:0]  exp_pstrb = '0;

    // Observations gathered per transaction for the literal checks.
    logic        cap_any_psel = 1'b0;
    logic [2:0]  cap_psel = '0;
    logic [31:0] cap_paddr = '0;
    logic [31:0] cap_pwdata = '0;
    logic [3:0]  cap_pstrb = '0;
    logic        cap_pwrite = 1'b0;
    int          low_cnt = 0;
    int          err_cnt = 0;

    always @(negedge hclk) begin
        if (exp_valid && hresetn) begin
            check("hreadyout", 64'(hreadyout), 64'(exp_hreadyout));
            check("hresp", 64'(hresp), 64'(exp_hresp));
            check("hrdata", 64'(hrdata), 64'(exp_hrdata));
            check("psel", 64'(psel), 64'(exp_psel));
            check("penable", 64'(penable), 64'(exp_penable));
            if (exp_psel != 3'b000) begin
                check("paddr", 64'(paddr), 64'(exp_paddr));
                check("pwrite", 64'(pwrite), 64'(exp_pwrite));
                check("pstrb", 64'(pstrb), 64'(exp_pstrb));
                if (exp_pwrite) check("pwdata", 64'(pwdata), 64'(exp_pwdata));
            end
            if (psel != 3'b000) begin
                cap_any_psel = 1'b1;
                cap_psel     = psel;
                cap_paddr    = paddr;
                cap_pwdata   = pwdata;
                cap_pstrb    = pstrb;
                cap_pwrite   = pwrite;
            end
            if (!hreadyout) low_cnt++;
            if (hresp == 2'b01) err_cnt++;
        end
    end

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    task automatic expect_bus(input logic rdy, input logic [1:0] resp, input logic [2:0] sel,
                              input logic pen);
        exp_hreadyout = rdy;
        exp_hresp     = resp;
        exp_psel      = sel;
        exp_penable   = pen;
    endtask

    task automatic clear_caps();
        cap_any_psel = 1'b0;
        cap_psel     = '0;
        low_cnt      = 0;
        err_cnt      = 0;
    endtask

    task automatic expect_reset_state();
        exp_hreadyout = 1'b1;
        exp_hresp     = 2'b00;
        exp_hrdata    = '0;
        exp_psel      = '0;
        exp_penable   = 1'b0;
    endtask

    // One AHB beat: starts in a cycle where hreadyout is expected high, returns in the
    // completion cycle (IDLE or ERR2) so a following call exercises back-to-back accept.
    task automatic xfer(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                        input logic [31:0] wdata, input logic [31:0] rdata,
                        input int waits, input logic serr);
        int          nbytes;
        logic        err;
        logic [3:0]  strb;
        logic [2:0]  sel;
        nbytes = 1 << size;
        err    = (int'(addr[29:28]) >= NUM_SLV) || (nbytes > DATA_W / 8)
              || ((addr & 32'(nbytes - 1)) != 32'd0);
        strb   = wr ? 4'(((1 << nbytes) - 1) << addr[1:0]) : 4'h0;
        sel    = 3'(1 << addr[29:28]);

        haddr  = addr;
        htrans = 2'b10;
        hwrite = wr;
        hsize  = size;
        hburst = 3'b001;
        hwdata = ~wdata;
        step();
        htrans = 2'b00;
        haddr  = 32'h0;
        if (err) begin
            expect_bus(1'b0, 2'b01, 3'b000, 1'b0);
            step();
            expect_bus(1'b1, 2'b01, 3'b000, 1'b0);
            return;
        end
        if (wr) begin
            expect_bus(1'b0, 2'b00, 3'b000, 1'b0);
            hwdata = wdata;
            step();
            hwdata = ~wdata;
        end
        expect_bus(1'b0, 2'b00, sel, 1'b0);
        exp_paddr  = addr;
        exp_pwrite = wr;
        exp_pstrb  = strb;
        exp_pwdata = wdata;
        pready     = 1'b0;
        step();
        for (int k = 0; k <= waits; k++) begin
            expect_bus(1'b0, 2'b00, sel, 1'b1);
            pready  = (k == waits);
            pslverr = (k == waits) ? serr : 1'b0;
            prdata  = (k == waits) ? rdata : ~rdata;
            step();
        end
        pready  = 1'b0;
        pslverr = 1'b0;
        prdata  = 32'hA5A5_0F0F;
        if (SLVERR_EN && serr) begin
            expect_bus(1'b0, 2'b01, 3'b000, 1'b0);
            step();
            expect_bus(1'b1, 2'b01, 3'b000, 1'b0);
        end else begin
            expect_bus(1'b1, 2'b00, 3'b000, 1'b0);
            if (!wr) exp_hrdata = rdata;
        end
    endtask

    task automatic idle(input int n, input logic [1:0] trans, input logic rdy_in);
        for (int i = 0; i < n; i++) begin
            htrans   = trans;
            hreadyin = rdy_in;
            haddr    = 32'h1000_0000 | ($urandom & 32'h0000_00FC);
            hwrite   = 1'($urandom);
            hsize    = 3'd2;
            step();
            expect_bus(1'b1, 2'b00, 3'b000, 1'b0);
        end
        htrans   = 2'b00;
        hreadyin = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values.
        step();
        step();
        check("rst_hreadyout", 64'(hreadyout), 64'h1);
        check("rst_hresp", 64'(hresp), 64'h0);
        check("rst_hrdata", 64'(hrdata), 64'h0);
        check("rst_psel", 64'(psel), 64'h0);
        check("rst_penable", 64'(penable), 64'h0);
        check("rst_paddr", 64'(paddr), 64'h0);
        check("rst_pwrite", 64'(pwrite), 64'h0);
        check("rst_pwdata", 64'(pwdata), 64'h0);
        check("rst_pstrb", 64'(pstrb), 64'h0);
        hresetn = 1'b1;
        expect_reset_state();
        exp_valid = 1'b1;
        idle(2, 2'b00, 1'b1);

        // Word write to slave 1, no APB wait.
        clear_caps();
        xfer(32'h1000_0004, 1'b1, 3'd2, 32'hDEAD_BEEF, 32'h0, 0, 1'b0);
        idle(1, 2'b00, 1'b1);
        check("wr_psel", 64'(cap_psel), 64'h2);
        check("wr_paddr", 64'(cap_paddr), 64'h1000_0004);
        check("wr_pstrb", 64'(cap_pstrb), 64'hF);
        check("wr_pwdata", 64'(cap_pwdata), 64'hDEAD_BEEF);
        check("wr_pwrite", 64'(cap_pwrite), 64'h1);
        check("wr_wait_cycles", 64'(low_cnt), 64'd3);
        check("wr_err_cycles", 64'(err_cnt), 64'd0);

        // Read from slave 2 with three APB wait cycles.
        clear_caps();
        xfer(32'h2000_0000, 1'b0, 3'd2, 32'h0, 32'h1234_5678, 3, 1'b0);
        idle(1, 2'b00, 1'b1);
        check("rd_psel", 64'(cap_psel), 64'h4);
        check("rd_pstrb", 64'(cap_pstrb), 64'h0);
        check("rd_wait_cycles", 64'(low_cnt), 64'd5);
        check("rd_hrdata", 64'(hrdata), 64'h1234_5678);
        check("rd_err_cycles", 64'(err_cnt), 64'd0);

        // Read completing with pslverr.
        clear_caps();
        xfer(32'h1000_0008, 1'b0, 3'd2, 32'h0, 32'hBAD0_BAD0, 0, 1'b1);
        idle(1, 2'b00, 1'b1);
        if (SLVERR_EN) begin
            check("slverr_hrdata", 64'(hrdata), 64'h1234_5678);
            check("slverr_err_cycles", 64'(err_cnt), 64'd2);
        end else begin
            check("slverr_hrdata", 64'(hrdata), 64'hBAD0_BAD0);
            check("slverr_err_cycles", 64'(err_cnt), 64'd0);
        end

        // Byte write to the top lane.
        clear_caps();
        xfer(32'h0000_0003, 1'b1, 3'd0, 32'h5A00_0000, 32'h0, 0, 1'b0);
        idle(1, 2'b00, 1'b1);
        check("byte_psel", 64'(cap_psel), 64'h1);
        check("byte_pstrb", 64'(cap_pstrb), 64'h8);

        // Misaligned halfword: two-cycle ERROR, no APB select.
        clear_caps();
        xfer(32'h0000_0001, 1'b1, 3'd1, 32'h1111_2222, 32'h0, 0, 1'b0);
        idle(1, 2'b00, 1'b1);
        check("misal_any_psel", 64'(cap_any_psel), 64'h0);
        check("misal_err_cycles", 64'(err_cnt), 64'd2);
        check("misal_wait_cycles", 64'(low_cnt), 64'd1);

        // Slave index out of range.
        clear_caps();
        xfer(32'h3000_0000, 1'b0, 3'd2, 32'h0, 32'h7777_7777, 0, 1'b0);
        idle(1, 2'b00, 1'b1);
        check("dec_any_psel", 64'(cap_any_psel), 64'h0);
        check("dec_err_cycles", 64'(err_cnt), 64'd2);
        check("dec_wait_cycles", 64'(low_cnt), 64'd1);

        // Back-to-back chain, including accepts taken in ERR2 and an oversize dword.
        xfer(32'h1000_0010, 1'b0, 3'd1, 32'h0, 32'h0000_BEEF, 0, 1'b0);
        xfer(32'h2000_0006, 1'b1, 3'd1, 32'hABCD_0000, 32'h0, 0, 1'b0);
        xfer(32'h0000_0002, 1'b0, 3'd2, 32'h0, 32'h0, 0, 1'b0);
        xfer(32'h0000_0000, 1'b0, 3'd3, 32'h0, 32'h0, 0, 1'b0);
        xfer(32'h2000_0008, 1'b0, 3'd2, 32'h0, 32'h55AA_55AA, 1, 1'b0);
        idle(1, 2'b00, 1'b1);
        check("chain_hrdata", 64'(hrdata), 64'h55AA_55AA);

        // BUSY and not-ready NONSEQ are ignored.
        clear_caps();
        idle(2, 2'b01, 1'b1);
        idle(2, 2'b10, 1'b0);
        check("ignored_any_psel", 64'(cap_any_psel), 64'h0);
        check("ignored_wait_cycles", 64'(low_cnt), 64'd0);

        // Reset asserted during ACCESS aborts the read.
        exp_valid = 1'b0;
        haddr  = 32'h0000_0008;
        hwrite = 1'b0;
        hsize  = 3'd2;
        htrans = 2'b10;
        pready = 1'b0;
        step();
        htrans = 2'b00;
        step();
        step();
        check("pre_rst_penable", 64'(penable), 64'h1);
        #2;
        hresetn = 1'b0;
        #1;
        check("arst_hreadyout", 64'(hreadyout), 64'h1);
        check("arst_hresp", 64'(hresp), 64'h0);
        check("arst_hrdata", 64'(hrdata), 64'h0);
        check("arst_psel", 64'(psel), 64'h0);
        check("arst_penable", 64'(penable), 64'h0);
        check("arst_paddr", 64'(paddr), 64'h0);
        check("arst_pwrite", 64'(pwrite), 64'h0);
        check("arst_pwdata", 64'(pwdata), 64'h0);
        check("arst_pstrb", 64'(pstrb), 64'h0);
        step();
        step();
        hresetn = 1'b1;
        expect_reset_state();
        exp_valid = 1'b1;
        idle(1, 2'b00, 1'b1);

        // First transfer after reset completes normally.
        clear_caps();
        xfer(32'h2000_0004, 1'b1, 3'd2, 32'hAABB_CCDD, 32'h0, 0, 1'b0);
        idle(1, 2'b00, 1'b1);
        check("post_rst_psel", 64'(cap_psel), 64'h4);
        check("post_rst_pwdata", 64'(cap_pwdata), 64'hAABB_CCDD);
        check("post_rst_wait_cycles", 64'(low_cnt), 64'd3);
        idle(2, 2'b00, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ahb2apb_bridge_p.md
# ahb2apb_bridge_p

Parametrised AHB-Lite slave to APB4 master bridge, successor to the fixed 32-bit, 3-slave bridge. It converts each accepted AHB beat into one APB transfer on one of `NUM_SLV` decoded slaves. It inserts AHB wait states while `pready` is low and returns byte strobes derived from `hsize`. It reports decode, size and slave errors as the two-cycle AHB ERROR response.

## Interface
- `DATA_W`, 32: AHB/APB data width; must be 32 or 64.
- `ADDR_W`, 32: address width.
- `NUM_SLV`, 3: APB slave count, 1..8.
- `SEL_LSB`, 28: LSB of the slave-index field `haddr[SEL_LSB +: $clog2(NUM_SLV)]`.

Ports:
- `hclk` in 1: clock.
- `hresetn` in 1: asynchronous, active-low reset.
- `haddr` in ADDR_W: AHB address.
- `htrans` in 2: transfer type. 0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ.
- `hwrite` in 1: 1 = write.
- `hsize` in 3: transfer size. 0 byte, 1 half, 2 word, 3 dword.
- `hburst` in 3: accepted, ignored; every beat is an independent APB transfer.
- `hwdata` in DATA_W: write data.
- `hreadyin` in 1: bus ready.
- `hrdata` out DATA_W: read data.
- `hreadyout` out 1: bridge ready.
- `hresp` out 2: 00 OKAY, 01 ERROR.
- `psel` out NUM_SLV: one-hot slave select.
- `penable` out 1: APB access phase.
- `paddr` out ADDR_W: APB address.
- `pwrite` out 1: APB direction.
- `pwdata` out DATA_W: APB write data.
- `pstrb` out DATA_W/8: APB byte strobes.
- `prdata` in DATA_W: APB read data, muxed externally.
- `pready` in 1: APB slave ready.
- `pslverr` in 1: APB slave error.

## Operation
- Accept condition: `hreadyin && htrans[1] && hreadyout`, evaluated in IDLE or ERR2. BUSY and IDLE transfer types are ignored. SEQ is handled identically to NONSEQ.
- On accept, register `haddr`, `hwrite`, `hsize` and the slave index.
- Decode error: slave index ≥ NUM_SLV, or `(8<<hsize) > DATA_W`, or the address is misaligned for `hsize`. Next state is ERR1; no APB activity occurs.
- FSM states: IDLE, WDATA, SETUP, ACCESS, ERR1, ERR2.
- IDLE → WDATA on accepted write; → SETUP on accepted read; → ERR1 on decode error.
- WDATA → SETUP unconditionally. In WDATA, capture `hwdata` into `pwdata`.
- SETUP: `psel[idx]`=1, `penable`=0. → ACCESS unconditionally.
- ACCESS: `penable`=1. Stay in ACCESS while `pready`=0.
- ACCESS on `pready`=1: if `pslverr`=1 (macro enabled) → ERR1; otherwise → IDLE with `hrdata` ← `prdata` on a read.
- ERR1: `hreadyout`=0, `hresp`=01. → ERR2.
- ERR2: `hreadyout`=1, `hresp`=01. → IDLE, or accepts a new transfer exactly as IDLE does.
- `pstrb` for writes: ones over bytes `haddr[log2(DATA_W/8)-1:0]` through that offset + `2^hsize` − 1. For reads `pstrb` = 0.
- `paddr`, `pwrite`, `pstrb` and `pwdata` are held stable from SETUP through the last ACCESS cycle. `psel` and `penable` are 0 in every other state.
- `hrdata` holds its last value until the next read completes.

## Timing
- All outputs are registered.
- Reset values: `hreadyout`=1, `hresp`=00, `hrdata`=0, `psel`=0, `penable`=0, `paddr`=0, `pwrite`=0, `pwdata`=0, `pstrb`=0. FSM resets to IDLE.
- Assertion of `hresetn` mid-transfer aborts the transfer immediately. The APB transfer is dropped with no completion.
- Read, address sampled at edge N: SETUP in cycle N+1, ACCESS in N+2. With zero APB wait, `hreadyout`=1 and `hrdata` is valid in N+3.
- Write: one extra cycle (WDATA), so `hreadyout`=1 in N+4.
- Each APB wait cycle (`pready`=0) adds exactly one AHB wait cycle.
- Back-to-back: a new transfer can be accepted in the same cycle `hreadyout` returns to 1.
- Error: ERR1 is the cycle after the decode edge or after the `pslverr` edge; ERR2 follows.

## Configuration
- `AHB2APB_PSLVERR_EN` defined: `pslverr` sampled with `pready`=1 causes the ERR1/ERR2 response. Read data is not updated on an errored read.
- Undefined: `pslverr` is ignored and completion is always OKAY. Decode and size errors still produce ERROR.

## Test plan
- Write `haddr`=0x1000_0004, `hsize`=2, `hwdata`=0xDEADBEEF, `pready`=1 → `psel`=3'b010, `paddr`=0x1000_0004, `pstrb`=4'hF, `pwdata`=0xDEADBEEF, `hreadyout`=1 at N+4 with OKAY.
- Read `haddr`=0x2000_0000, `prdata`=0x1234_5678, `pready` low for 3 cycles → `psel`=3'b100, `hreadyout` low 5 cycles, `hrdata`=0x1234_5678, OKAY.
- Byte write to `haddr`=0x0000_0003, `hsize`=0 → `pstrb`=4'b1000. Halfword write to 0x0000_0001 → ERR1/ERR2 with no `psel`.
- Access `haddr`=0x3000_0000 with NUM_SLV=3 → `hresp`=01 for two cycles, `hreadyout` 0 then 1, `psel` stays 0.
- With macro defined, read completing with `pslverr`=1 → two-cycle ERROR and `hrdata` unchanged. With macro undefined, same stimulus → OKAY.
- Assert `hresetn` during ACCESS → all outputs at reset values immediately. The next accepted transfer completes normally.
